// File: rtl/pixel_stream_packer.sv
// Buffers generator pixel strobes in a FWFT FIFO and re-emits them as AXI4-Stream video with tuser/tlast.
// Optional PIXEL_STREAM_STATS_EN adds drop_count and frame_count outputs.
module pixel_stream_packer #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int DIM_W      = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [31:0]                   width,
  input  logic [31:0]                   height,
  input  logic [DATA_W-1:0]             pixel_data,
  input  logic                          pixel_valid,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          frame_active,
  output logic                          frame_done,
  output logic                          overflow,
`ifdef PIXEL_STREAM_STATS_EN
  output logic [15:0]                   drop_count,
  output logic [15:0]                   frame_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_count;
  logic [DIM_W-1:0]  r_w, r_h, r_col, r_row;
  logic              r_done, r_overflow;

  logic w_start_ok, w_full, w_tvalid, w_rd, w_wr, w_drop, w_last, w_flush, w_col_end;
  logic w_unused_bits;

  assign w_unused_bits = ^{width[31:DIM_W], height[31:DIM_W]};

  assign w_start_ok = start && (width[DIM_W-1:0] != '0) && (height[DIM_W-1:0] != '0);
  assign w_full     = (r_count == LW'(FIFO_DEPTH));
  assign w_tvalid   = (r_state == S_STREAM) && (r_count != '0);
  assign w_rd       = w_tvalid && m_axis_tready;
  assign w_col_end  = (r_col == r_w - DIM_W'(1));
  assign w_last     = w_rd && w_col_end && (r_row == r_h - DIM_W'(1));
  // A restart in the same cycle as a strobe flushes; the strobe is discarded without flagging overflow.
  assign w_wr       = (r_state == S_STREAM) && pixel_valid && !w_start_ok && (!w_full || w_rd);
  assign w_drop     = (r_state == S_STREAM) && pixel_valid && !w_start_ok && !w_wr;
  assign w_flush    = w_start_ok || w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start_ok)
      w_state_nxt = S_STREAM;
    else if (r_state == S_STREAM && w_last)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= pixel_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w   <= '0;
      r_h   <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (w_start_ok) begin
      r_w   <= width[DIM_W-1:0];
      r_h   <= height[DIM_W-1:0];
      r_col <= '0;
      r_row <= '0;
    end else if (w_rd) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + DIM_W'(1);
      end else begin
        r_col <= r_col + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_last && !w_start_ok;
      if (w_start_ok)  r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef PIXEL_STREAM_STATS_EN
  logic [15:0] r_drop_count, r_frame_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count  <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_start_ok)
        r_drop_count <= '0;
      else if (w_drop && r_drop_count != 16'hFFFF)
        r_drop_count <= r_drop_count + 16'd1;
      if (r_done) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign drop_count  = r_drop_count;
  assign frame_count = r_frame_count;
`endif

  // Outputs are gated by tvalid so nothing leaks from the unreset storage array.
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tdata  = w_tvalid ? r_mem[r_rd_ptr] : '0;
  assign m_axis_tuser  = w_tvalid && (r_row == '0) && (r_col == '0);
  assign m_axis_tlast  = w_tvalid && w_col_end;
  assign frame_active  = (r_state == S_STREAM);
  assign frame_done    = r_done;
  assign overflow      = r_overflow;
  assign fifo_level    = r_count;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed self-checking bench for pixel_stream_packer (default 24-bit, 16-deep FIFO).
// Build with PIXEL_STREAM_STATS_EN defined to also check the statistics outputs.
module tb_pixel_stream_packer;

  logic        clk = 1'b0;
  logic        reset, start, pixel_valid, m_axis_tready;
  logic [31:0] width, height;
  logic [23:0] pixel_data, m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic        frame_active, frame_done, overflow;
  logic [4:0]  fifo_level;
`ifdef PIXEL_STREAM_STATS_EN
  logic [15:0] drop_count, frame_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [23:0] b_data [64];
  logic        b_user [64];
  logic        b_last [64];
  int          n_beats = 0;
  int          n_done  = 0;

  always #5 clk = ~clk;

  pixel_stream_packer dut (
    .clk(clk), .reset(reset), .start(start), .width(width), .height(height),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .frame_active(frame_active), .frame_done(frame_done), .overflow(overflow),
`ifdef PIXEL_STREAM_STATS_EN
    .drop_count(drop_count), .frame_count(frame_count),
`endif
    .fifo_level(fifo_level)
  );

  // Inputs only move #1 after posedge, so the negedge sees what the next edge will accept.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_axis_tvalid && m_axis_tready && n_beats < 64) begin
        b_data[n_beats] = m_axis_tdata;
        b_user[n_beats] = m_axis_tuser;
        b_last[n_beats] = m_axis_tlast;
        n_beats++;
      end
      if (frame_done) n_done++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [31:0] w, input logic [31:0] h);
    start  = 1'b1;
    width  = w;
    height = h;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic strobes(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1;
      pixel_data  = base + 24'(i);
      tick(1);
    end
    pixel_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; width = 0; height = 0;
    pixel_valid = 1'b0; pixel_data = '0; m_axis_tready = 1'b0;
    tick(2);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_active", frame_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_level", fifo_level, 0);
    reset = 1'b0;
    tick(1);

    // 1: 4x2 frame, sink always ready
    m_axis_tready = 1'b1; n_beats = 0; n_done = 0;
    do_start(4, 2);
    check("t1_active", frame_active, 1);
    strobes(8, 24'd1);
    tick(5);
    check("t1_beats", n_beats, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t1_data%0d", i), b_data[i], 32'(i + 1));
    check("t1_user0", b_user[0], 1);
    check("t1_user1", b_user[1], 0);
    check("t1_user4", b_user[4], 0);
    check("t1_last0", b_last[0], 0);
    check("t1_last3", b_last[3], 1);
    check("t1_last4", b_last[4], 0);
    check("t1_last7", b_last[7], 1);
    check("t1_done", n_done, 1);
    check("t1_active_end", frame_active, 0);
    check("t1_ovf", overflow, 0);
`ifdef PIXEL_STREAM_STATS_EN
    check("t1_fcount", frame_count, 1);
`endif

    // 2: 20 stalled cycles during the strobes, then release
    m_axis_tready = 1'b0; n_beats = 0; n_done = 0;
    do_start(4, 2);
    strobes(8, 24'h10);
    tick(12);
    check("t2_level", fifo_level, 8);
    check("t2_ovf", overflow, 0);
    check("t2_beats_stall", n_beats, 0);
    check("t2_tvalid", m_axis_tvalid, 1);
    check("t2_hold_data", m_axis_tdata, 32'h10);
    check("t2_hold_user", m_axis_tuser, 1);
    check("t2_hold_last", m_axis_tlast, 0);
    m_axis_tready = 1'b1;
    tick(12);
    check("t2_beats", n_beats, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_data%0d", i), b_data[i], 32'h10 + 32'(i));
    check("t2_last3", b_last[3], 1);
    check("t2_last7", b_last[7], 1);
    check("t2_done", n_done, 1);

    // 3: overflow with 18 strobes into 16 entries
    m_axis_tready = 1'b0; n_beats = 0;
    do_start(4, 8);
    strobes(18, 24'h100);
    check("t3_level", fifo_level, 16);
    check("t3_ovf", overflow, 1);
    check("t3_beats", n_beats, 0);
`ifdef PIXEL_STREAM_STATS_EN
    check("t3_drops", drop_count, 2);
`endif

    // 4: full FIFO, strobe coincides with a handshake
    do_start(4, 8);
    check("t4_flush", fifo_level, 0);
    check("t4_ovf_clr", overflow, 0);
`ifdef PIXEL_STREAM_STATS_EN
    check("t4_drops_clr", drop_count, 0);
`endif
    strobes(16, 24'h200);
    check("t4_full", fifo_level, 16);
    n_beats = 0;
    m_axis_tready = 1'b1; pixel_valid = 1'b1; pixel_data = 24'h2FF;
    tick(1);
    m_axis_tready = 1'b0; pixel_valid = 1'b0;
    check("t4_level", fifo_level, 16);
    check("t4_ovf", overflow, 0);
    check("t4_beats", n_beats, 1);
    check("t4_beat_data", b_data[0], 32'h200);
    check("t4_head", m_axis_tdata, 32'h201);

    // 5: restart after 3 beats with a 2x1 frame
    n_beats = 0; n_done = 0;
    do_start(4, 2);
    strobes(5, 24'h300);
    m_axis_tready = 1'b1;
    tick(3);
    m_axis_tready = 1'b0;
    do_start(2, 1);
    check("t5_beats_pre", n_beats, 3);
    check("t5_data2", b_data[2], 32'h302);
    check("t5_level", fifo_level, 0);
    check("t5_active", frame_active, 1);
    n_beats = 0;
    m_axis_tready = 1'b1;
    strobes(2, 24'h400);
    tick(4);
    check("t5_beats", n_beats, 2);
    check("t5_data0", b_data[0], 32'h400);
    check("t5_user0", b_user[0], 1);
    check("t5_last0", b_last[0], 0);
    check("t5_user1", b_user[1], 0);
    check("t5_last1", b_last[1], 1);
    check("t5_done", n_done, 1);
    check("t5_active_end", frame_active, 0);

    // 6: asynchronous reset mid-frame, then a zero-width start
    m_axis_tready = 1'b0;
    do_start(4, 8);
    strobes(18, 24'h500);
    check("t6_ovf_pre", overflow, 1);
    check("t6_tvalid_pre", m_axis_tvalid, 1);
    #3 reset = 1'b1;
    #1;
    check("t6_tvalid", m_axis_tvalid, 0);
    check("t6_tdata", m_axis_tdata, 0);
    check("t6_tuser", m_axis_tuser, 0);
    check("t6_active", frame_active, 0);
    check("t6_level", fifo_level, 0);
    check("t6_ovf", overflow, 0);
    tick(1);
    reset = 1'b0;
    n_beats = 0;
    m_axis_tready = 1'b1;
    do_start(0, 2);
    check("t6_w0_active", frame_active, 0);
    strobes(2, 24'h600);
    tick(3);
    check("t6_w0_level", fifo_level, 0);
    check("t6_w0_ovf", overflow, 0);
    check("t6_no_beats", n_beats, 0);
`ifdef PIXEL_STREAM_STATS_EN
    check("t6_fcount", frame_count, 0);
    check("t6_drops", drop_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
